// File: rtl/operand_pair_serializer.sv
// operand_pair_serializer
//   Transmit side of the DL_float operand register wrapper. Operand pairs
//   (A, B) are accepted in parallel into a small pair FIFO. They are then
//   streamed out one word per transfer on a valid/ready bus, A first and
//   B second. The downstream wrapper rebuilds reg_a/reg_b from this stream.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   reg_a      operand A of the offered pair
//   reg_b      operand B of the offered pair
//   load       offer pair; accepted when load && load_ready at an edge
//   load_ready FIFO has room (combinational, count only)
//   data_out   serialized word (registered)
//   data_valid data_out holds a valid word (registered)
//   data_ready sink accepts data_out
//   is_b       0: word is A, 1: word is B (registered)
//   count      pairs held in the FIFO, excluding the output stage
//   busy       data_valid || count != 0
module operand_pair_serializer #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          reg_a,
   input  logic [DATA_W-1:0]          reg_b,
   input  logic                       load,
   output logic                       load_ready,
   output logic [DATA_W-1:0]          data_out,
   output logic                       data_valid,
   input  logic                       data_ready,
   output logic                       is_b,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} state_t;

   state_t                state;
   logic [2*DATA_W-1:0]   mem [DEPTH];
   logic [AW-1:0]         wptr, rptr;
   logic [2*DATA_W-1:0]   head;
   logic                  push, pop, xfer, have;
   logic [DATA_W-1:0]     b_hold;

   // A full FIFO refuses a load even when a pop happens on the same edge.
   // Keeping load_ready a function of count alone avoids a combinational
   // path from data_ready to load_ready.
   assign load_ready = (count != CW'(DEPTH));
   assign busy       = data_valid || (count != '0);
   assign push       = load && load_ready;
   assign xfer       = data_valid && data_ready;
   assign have       = (count != '0);
   assign head       = mem[rptr];

   // The FIFO is popped only when the FSM enters SEND_A.
   always_comb begin
      pop = 1'b0;
      case (state)
         IDLE:    pop = have;
         SEND_B:  pop = xfer && have;
         default: pop = 1'b0;
      endcase
   end

   // Pair storage: A sits in the upper half, B in the lower half.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= {reg_a, reg_b};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         data_out   <= '0;
         data_valid <= 1'b0;
         is_b       <= 1'b0;
         b_hold     <= '0;
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         case (state)
            IDLE: begin
               if (have) begin
                  data_out   <= head[2*DATA_W-1:DATA_W];
                  b_hold     <= head[DATA_W-1:0];
                  is_b       <= 1'b0;
                  data_valid <= 1'b1;
                  state      <= SEND_A;
               end
            end
            SEND_A: begin
               if (xfer) begin
                  // B is held in b_hold because the FIFO slot was already
                  // released on entry to SEND_A and may be overwritten.
                  data_out <= b_hold;
                  is_b     <= 1'b1;
                  state    <= SEND_B;
               end
            end
            SEND_B: begin
               if (xfer) begin
                  if (have) begin
                     // Back-to-back: the next A follows with no bubble.
                     data_out <= head[2*DATA_W-1:DATA_W];
                     b_hold   <= head[DATA_W-1:0];
                     is_b     <= 1'b0;
                     state    <= SEND_A;
                  end else begin
                     data_valid <= 1'b0;
                     is_b       <= 1'b0;
                     state      <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_pair_serializer.sv
module tb_operand_pair_serializer;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] reg_a, reg_b;
   logic              load, load_ready;
   logic [DATA_W-1:0] data_out;
   logic              data_valid, data_ready, is_b, busy;
   logic [2:0]        count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [DATA_W-1:0] word;
      logic              b;
   } exp_t;
   exp_t sb[$];

   operand_pair_serializer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .reg_a(reg_a), .reg_b(reg_b), .load(load),
      .load_ready(load_ready), .data_out(data_out), .data_valid(data_valid),
      .data_ready(data_ready), .is_b(is_b), .count(count), .busy(busy)
   );

   always #5 clk = ~clk;

   // Transfer monitor. Inputs change 1 ns after the rising edge, so at the
   // falling edge a valid && ready means a transfer on the next rising edge.
   always @(negedge clk) begin
      if (rst && data_valid && data_ready) begin
         exp_t e;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL xfer_unexpected: got word %h is_b %b, no word expected", data_out, is_b);
         end else begin
            e = sb.pop_front();
            if (data_out !== e.word || is_b !== e.b) begin
               errors++;
               $display("FAIL xfer_word: got %h/%b, expected %h/%b", data_out, is_b, e.word, e.b);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_pair(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      sb.push_back('{word: a, b: 1'b0});
      sb.push_back('{word: b, b: 1'b1});
   endtask

   // Drain with ready high until idle; bounded.
   task automatic drain(input string name);
      int n = 0;
      data_ready = 1'b1;
      while (busy && n < 200) begin tick(); n++; end
      checks++;
      if (busy !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL %s_drain: busy %b count %0d, expected busy 0 count 0", name, busy, count);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; load = 1'b0; data_ready = 1'b0; reg_a = '0; reg_b = '0;
      #2;
      checks++;
      if (data_out !== 16'h0 || data_valid !== 1'b0 || is_b !== 1'b0 || count !== 3'd0 ||
          load_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: out %h v %b b %b cnt %0d lr %b busy %b, expected 0 0 0 0 1 0",
                  data_out, data_valid, is_b, count, load_ready, busy);
      end
      tick(); tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single();
      data_ready = 1'b1;
      reg_a = 16'hBEA3; reg_b = 16'h4073; load = 1'b1;
      exp_pair(16'hBEA3, 16'h4073);
      tick();                  // edge N
      load = 1'b0;
      checks++;
      if (data_valid !== 1'b0 || count !== 3'd1) begin
         errors++;
         $display("FAIL single_N: valid %b count %0d, expected 0 1", data_valid, count);
      end
      tick();                  // N+1
      checks++;
      if (data_valid !== 1'b1 || data_out !== 16'hBEA3 || is_b !== 1'b0) begin
         errors++;
         $display("FAIL single_A: %b %h %b, expected 1 BEA3 0", data_valid, data_out, is_b);
      end
      tick();                  // N+2
      checks++;
      if (data_valid !== 1'b1 || data_out !== 16'h4073 || is_b !== 1'b1) begin
         errors++;
         $display("FAIL single_B: %b %h %b, expected 1 4073 1", data_valid, data_out, is_b);
      end
      tick();                  // N+3
      checks++;
      if (data_valid !== 1'b0 || busy !== 1'b0 || is_b !== 1'b0) begin
         errors++;
         $display("FAIL single_end: valid %b busy %b is_b %b, expected 0 0 0", data_valid, busy, is_b);
      end
   endtask

   task automatic test_backpressure();
      data_ready = 1'b0;
      reg_a = 16'hBEA3; reg_b = 16'h4073; load = 1'b1;
      exp_pair(16'hBEA3, 16'h4073);
      tick();
      load = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (data_valid !== 1'b1 || data_out !== 16'hBEA3 || is_b !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: %b %h %b, expected 1 BEA3 0", i, data_valid, data_out, is_b);
         end
         tick();
      end
      data_ready = 1'b1;
      tick();
      checks++;
      if (data_valid !== 1'b1 || data_out !== 16'h4073 || is_b !== 1'b1) begin
         errors++;
         $display("FAIL bp_B: %b %h %b, expected 1 4073 1", data_valid, data_out, is_b);
      end
      tick();
      checks++;
      if (data_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_end: valid %b, expected 0", data_valid);
      end
   endtask

   // Five loads with the sink stalled: pair 1 lands in the output stage and
   // the other four fill the FIFO.
   task automatic fill5();
      data_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         reg_a = 16'(12 + 2*i); reg_b = 16'(13 + 2*i); load = 1'b1;
         exp_pair(16'(12 + 2*i), 16'(13 + 2*i));
         tick();
      end
      load = 1'b0;
   endtask

   task automatic test_fill();
      fill5();
      checks++;
      if (count !== 3'd4 || load_ready !== 1'b0 || data_out !== 16'h000C) begin
         errors++;
         $display("FAIL fill_full: count %0d lr %b out %h, expected 4 0 000C", count, load_ready, data_out);
      end
      reg_a = 16'h0016; reg_b = 16'h0017; load = 1'b1;   // dropped
      tick();
      load = 1'b0;
      checks++;
      if (count !== 3'd4) begin
         errors++;
         $display("FAIL fill_drop: count %0d, expected 4", count);
      end
      data_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (data_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_bubble[%0d]: valid %b, expected 1", i, data_valid);
         end
         tick();
      end
      checks++;
      if (data_valid !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL fill_end: valid %b count %0d, expected 0 0", data_valid, count);
      end
   endtask

   task automatic test_wrap();
      data_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         reg_a = 16'h1000 + 16'(i); reg_b = 16'h2000 + 16'(i); load = 1'b1;
         exp_pair(16'h1000 + 16'(i), 16'h2000 + 16'(i));
         tick();
         load = 1'b0;
         tick();
      end
      drain("wrap");
   endtask

   task automatic test_push_pop_full();
      fill5();
      data_ready = 1'b1;
      tick();                  // A of pair 1 leaves, now in SEND_B
      reg_a = 16'h00AA; reg_b = 16'h00AB; load = 1'b1;
      checks++;
      if (count !== 3'd4 || load_ready !== 1'b0 || is_b !== 1'b1) begin
         errors++;
         $display("FAIL ppf_pre: count %0d lr %b is_b %b, expected 4 0 1", count, load_ready, is_b);
      end
      tick();                  // pop and rejected load on the same edge
      load = 1'b0;
      checks++;
      if (count !== 3'd3) begin
         errors++;
         $display("FAIL ppf_count: count %0d, expected 3", count);
      end
      drain("ppf");
   endtask

   task automatic test_async_reset();
      data_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         reg_a = 16'h3000 + 16'(i); reg_b = 16'h4000 + 16'(i); load = 1'b1;
         exp_pair(16'h3000 + 16'(i), 16'h4000 + 16'(i));
         tick();
      end
      load = 1'b0;
      data_ready = 1'b1;
      tick();                  // A transferred, now SEND_B
      data_ready = 1'b0;
      checks++;
      if (is_b !== 1'b1 || count !== 3'd2) begin
         errors++;
         $display("FAIL ar_pre: is_b %b count %0d, expected 1 2", is_b, count);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (data_valid !== 1'b0 || count !== 3'd0 || busy !== 1'b0 || load_ready !== 1'b1) begin
         errors++;
         $display("FAIL ar_now: valid %b count %0d busy %b lr %b, expected 0 0 0 1",
                  data_valid, count, busy, load_ready);
      end
      sb.delete();
      data_ready = 1'b1;
      tick(); tick();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_stale[%0d]: valid %b, expected 0", i, data_valid);
         end
         tick();
      end
      reg_a = 16'h5A5A; reg_b = 16'hA5A5; load = 1'b1;
      exp_pair(16'h5A5A, 16'hA5A5);
      tick();
      load = 1'b0;
      drain("ar");
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_fill();
      test_wrap();
      test_push_pop_full();
      test_async_reset();
      tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_left: %0d words never seen, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
